// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one load/store at a time over valid/ready,
// committed after LATENCY wait cycles and answered on a valid/ready response channel.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            accept;
    logic            commit;
    logic            addr_err;
    logic [AW-1:0]   idx;
    logic [31:0]     mem [DEPTH];

    // Handshakes: a transfer happens on an edge where valid and ready are both
    // high; ready is a function of state only, never of the partner's valid.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_INIT;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end else begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_o   = (state != IDLE);
    assign idx      = addr_q[AW+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                rsp_err   <= addr_err;
                rsp_rdata <= (addr_err || we_q) ? 32'h0 : mem[idx];
            end
        end
    end

    // Storage is deliberately left out of reset; commit is never high while
    // reset holds the FSM in IDLE, so an interrupted store cannot land.
    always_ff @(posedge clk) begin
        if (commit && we_q && !addr_err) mem[idx] <= wdata_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed + randomized bench for dmem_responder: one LATENCY=2 and one LATENCY=1
// instance checked against an address-rule reference model.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        v2, v1;
    logic        rdy2, rdy1, rv2, rv1, err2, err1, busy2, busy1;
    logic [31:0] rd2, rd1;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [2][DEPTH];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_ready(rsp_ready),
        .rsp_rdata(rd2), .rsp_err(err2), .busy_o(busy2)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_ready(rsp_ready),
        .rsp_rdata(rd1), .rsp_err(err1), .busy_o(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic f_rdy(input bit s);
        return s ? rdy1 : rdy2;
    endfunction
    function automatic logic f_rv(input bit s);
        return s ? rv1 : rv2;
    endfunction
    function automatic logic f_err(input bit s);
        return s ? err1 : err2;
    endfunction
    function automatic logic f_busy(input bit s);
        return s ? busy1 : busy2;
    endfunction
    function automatic logic [31:0] f_rdata(input bit s);
        return s ? rd1 : rd2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full request/response; the model derives the expected result from the
    // address rules, and the bench optionally stalls the response or scrambles
    // the request inputs while the access is in flight.
    task automatic do_txn(input bit s, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input int stall, input bit noisy);
        int          n;
        int          bc;
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_rd;
        logic        exp_er;
        lat    = s ? 1 : 2;
        exp_er = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
        exp_rd = (exp_er || we) ? 32'h0 : model[s][a[7:2]];
        if (!exp_er && we) model[s][a[7:2]] = d;

        rsp_ready = (stall == 0);
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        if (s) v1 = 1'b1; else v2 = 1'b1;
        chk("req_ready_idle", 32'(f_rdy(s)), 32'd1);
        step();
        v1 = 1'b0;
        v2 = 1'b0;

        n  = 0;
        bc = int'(f_busy(s));
        while (!f_rv(s) && n < 20) begin
            chk("req_ready_wait", 32'(f_rdy(s)), 32'd0);
            if (noisy) begin
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_we    = ~we;
                if (s) v1 = 1'b1; else v2 = 1'b1;
            end
            step();
            n++;
            bc += int'(f_busy(s));
        end
        v1 = 1'b0;
        v2 = 1'b0;
        chk("latency", 32'(n), 32'(lat));
        chk("busy_cycles", 32'(bc), 32'(lat + 1));

        rd = f_rdata(s);
        er = f_err(s);
        chk("rsp_err", 32'(er), 32'(exp_er));
        chk("rsp_rdata", rd, exp_rd);

        for (int k = 0; k < stall; k++) begin
            step();
            chk("stall_valid", 32'(f_rv(s)), 32'd1);
            chk("stall_rdata", f_rdata(s), rd);
            chk("stall_err", 32'(f_err(s)), 32'(er));
            chk("stall_req_ready", 32'(f_rdy(s)), 32'd0);
        end

        rsp_ready = 1'b1;
        step();
        chk("idle_req_ready", 32'(f_rdy(s)), 32'd1);
        chk("idle_rsp_valid", 32'(f_rv(s)), 32'd0);
        chk("idle_busy", 32'(f_busy(s)), 32'd0);
    endtask

    initial begin
        logic        we;
        logic [31:0] a;

        v1 = 1'b0; v2 = 1'b0; rsp_ready = 1'b1;
        req_we = 1'b0; req_addr = '0; req_wdata = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_req_ready", 32'(rdy2), 32'd1);
        chk("rst_rsp_valid", 32'(rv2), 32'd0);
        chk("rst_rdata", rd2, 32'h0);
        chk("rst_err", 32'(err2), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_busy_l1", 32'(busy1), 32'd0);
        #19 reset = 1'b1;
        step();

        // store then load
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 0, 0);

        // response backpressure
        do_txn(0, 1'b0, 32'h10, 32'h0, 5, 0);

        // error cases leave word 0 untouched
        do_txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 0, 0);
        do_txn(0, 1'b1, 32'h2, 32'h12345678, 0, 0);
        do_txn(0, 1'b1, 32'h100, 32'h12345678, 0, 0);
        do_txn(0, 1'b0, 32'h0, 32'h0, 0, 0);
        do_txn(0, 1'b0, 32'h100, 32'h0, 0, 0);

        // request inputs scrambled while in flight
        do_txn(0, 1'b1, 32'h14, 32'h0BADF00D, 0, 1);
        do_txn(0, 1'b0, 32'h14, 32'h0, 0, 1);

        // reset during WAIT drops the pending store
        do_txn(0, 1'b1, 32'h20, 32'h11111111, 0, 0);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
        v2 = 1'b1;
        chk("rst_mid_accept_ready", 32'(rdy2), 32'd1);
        step();
        v2 = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_mid_req_ready", 32'(rdy2), 32'd1);
        chk("rst_mid_rsp_valid", 32'(rv2), 32'd0);
        chk("rst_mid_rdata", rd2, 32'h0);
        chk("rst_mid_err", 32'(err2), 32'd0);
        chk("rst_mid_busy", 32'(busy2), 32'd0);
        repeat (2) @(posedge clk);
        #4 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rst_mid_no_rsp", 32'(rv2), 32'd0);
        end
        do_txn(0, 1'b0, 32'h20, 32'h0, 0, 0);

        // LATENCY=1 randomized back-to-back sweep
        for (int i = 0; i < 4; i++) do_txn(1, 1'b1, 32'(i * 4), $urandom, 0, 0);
        for (int i = 0; i < 10; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
            do_txn(1, we, a, $urandom, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
